// File: rtl/muxn_pkg.sv
// Shared constants and index helper for the N-way select pipeline stage.
package muxn_pkg;

  localparam int MUXN_MAX_IN    = 32;
  localparam int MUXN_DEF_WIDTH = 16;

  // Out-of-range selects fall back to a fixed input rather than producing X.
  function automatic int muxn_idx(input int sel, input int num_in, input int default_idx);
    return (sel < num_in) ? sel : default_idx;
  endfunction

endpackage

// File: rtl/muxn_sel.sv
// Purely combinational N-way word select from a packed input bus.
module muxn_sel #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 6,
  parameter int SEL_W  = 3
) (
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]        idx,
  output logic [WIDTH-1:0]        word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (idx == SEL_W'(i)) word = data_in[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/muxn_stage.sv
// Registered N-way select stage with valid/ready handshake, flush and sticky select error.
// Define MUXN_STAGE_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module muxn_stage
  import muxn_pkg::*;
#(
  parameter int WIDTH       = MUXN_DEF_WIDTH,
  parameter int NUM_IN      = 6,
  parameter int DEFAULT_IDX = 0,
  localparam int SEL_W      = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err,
  input  logic                    err_clr
);

  // With a power-of-two input count every select value is legal.
  localparam bit CAN_ERR = (NUM_IN != (1 << SEL_W));

  logic [SEL_W-1:0] idx;
  logic [WIDTH-1:0] word;
  logic             bad_sel;
  logic             fire_in;
  logic             fire_out;

  assign idx      = SEL_W'(muxn_idx(int'(sel), NUM_IN, DEFAULT_IDX));
  assign bad_sel  = CAN_ERR && (int'(sel) >= NUM_IN);
  assign fire_in  = in_valid && in_ready && !flush;
  assign fire_out = out_valid && out_ready;

  muxn_sel #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .data_in (data_in),
    .idx     (idx),
    .word    (word)
  );

`ifdef MUXN_STAGE_SKID_EN
  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;
  logic             skid_valid;

  assign in_ready = !skid_valid;

  // A word arriving while the output is stalled parks in the skid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_sel   <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (fire_out) begin
        out_data   <= skid_data;
        out_sel    <= skid_sel;
        skid_valid <= 1'b0;
      end
    end else if (fire_in) begin
      if (out_valid && !out_ready) begin
        skid_data  <= word;
        skid_sel   <= idx;
        skid_valid <= 1'b1;
      end else begin
        out_data  <= word;
        out_sel   <= idx;
        out_valid <= 1'b1;
      end
    end else if (fire_out) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire_in) begin
      out_data  <= word;
      out_sel   <= idx;
      out_valid <= 1'b1;
    end else if (fire_out) begin
      out_valid <= 1'b0;
    end
  end
`endif

  // Set has priority over clear so a bad select in the clearing cycle is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (fire_in && bad_sel) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_muxn_stage.sv
// Directed self-checking bench for muxn_stage (WIDTH=16, NUM_IN=6).
module tb_muxn_stage;

`ifdef MUXN_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  sel;
  logic [95:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_sel;
  logic        sel_err;
  logic        err_clr;

  int checks;
  int failures;

  muxn_stage #(
    .WIDTH       (16),
    .NUM_IN      (6),
    .DEFAULT_IDX (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .sel_err   (sel_err),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setData(input logic [15:0] base);
    for (int i = 0; i < 6; i++) data_in[i*16 +: 16] = base + 16'(i);
  endtask

  task automatic applyStimulus(input logic iv, input logic [2:0] s, input logic ordy);
    in_valid  = iv;
    sel       = s;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    err_clr  = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b0);
    setData(16'h1000);

    #2;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'd0);
    checkOutput("rst_out_sel",   32'(out_sel),   32'd0);
    checkOutput("rst_sel_err",   32'(sel_err),   32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    // Single word, then out-of-range selects and sticky error handling
    applyStimulus(1'b1, 3'd3, 1'b1);
    tick();
    checkOutput("single_valid", 32'(out_valid), 32'd1);
    checkOutput("single_data",  32'(out_data),  32'h1003);
    checkOutput("single_sel",   32'(out_sel),   32'd3);
    checkOutput("single_err",   32'(sel_err),   32'd0);
    applyStimulus(1'b1, 3'd6, 1'b1);
    tick();
    checkOutput("sel6_data", 32'(out_data), 32'h1000);
    checkOutput("sel6_sel",  32'(out_sel),  32'd0);
    checkOutput("sel6_err",  32'(sel_err),  32'd1);
    applyStimulus(1'b1, 3'd7, 1'b1);
    tick();
    checkOutput("sel7_data", 32'(out_data), 32'h1000);
    checkOutput("sel7_err",  32'(sel_err),  32'd1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    tick();
    checkOutput("drain_valid", 32'(out_valid), 32'd0);
    checkOutput("err_sticky",  32'(sel_err),   32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("err_cleared", 32'(sel_err), 32'd0);
    err_clr = 1'b1;
    applyStimulus(1'b1, 3'd6, 1'b1);
    tick();
    err_clr = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("err_set_wins", 32'(sel_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("err_cleared2", 32'(sel_err),   32'd0);
    checkOutput("idle_valid",   32'(out_valid), 32'd0);

    // Back-pressure: first word must hold while data_in changes
    applyStimulus(1'b1, 3'd2, 1'b0);
    tick();
    checkOutput("bp_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_data",  32'(out_data),  32'h1002);
    applyStimulus(1'b1, 3'd4, 1'b0);
    #1;
    checkOutput("bp_in_ready_first", 32'(in_ready), 32'(SKID));
    tick();
    applyStimulus(1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      setData(16'h2000 + 16'(k * 16'h100));
      tick();
      checkOutput("bp_hold_data",  32'(out_data),  32'h1002);
      checkOutput("bp_hold_sel",   32'(out_sel),   32'd2);
      checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready",   32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(in_ready), 32'(!SKID));
    tick();
    checkOutput("bp_second_valid", 32'(out_valid), 32'(SKID));
`ifdef MUXN_STAGE_SKID_EN
    checkOutput("bp_second_data", 32'(out_data), 32'h1004);
    checkOutput("bp_second_sel",  32'(out_sel),  32'd4);
`endif
    tick();
    checkOutput("bp_empty", 32'(out_valid), 32'd0);
    setData(16'h1000);

    // Full throughput with sel cycling 0..5
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 3'(i % 6), 1'b1);
      tick();
      checkOutput("tp_valid", 32'(out_valid), 32'd1);
      checkOutput("tp_data",  32'(out_data),  32'h1000 + 32'(i % 6));
    end
    applyStimulus(1'b0, 3'd0, 1'b1);
    tick();
    checkOutput("tp_drain", 32'(out_valid), 32'd0);

    // Flush drops held and incoming words, even an out-of-range one
    applyStimulus(1'b1, 3'd2, 1'b0);
    tick();
    checkOutput("fl_held", 32'(out_data), 32'h1002);
    applyStimulus(1'b1, 3'd6, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("fl_valid", 32'(out_valid), 32'd0);
    checkOutput("fl_data",  32'(out_data),  32'h1002);
    checkOutput("fl_err",   32'(sel_err),   32'd0);
    checkOutput("fl_ready", 32'(in_ready),  32'd1);
    tick();
    checkOutput("fl_no_emit", 32'(out_valid), 32'd0);

    // Async reset between edges while a word is held
    applyStimulus(1'b1, 3'd1, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("ar_pre_valid", 32'(out_valid), 32'd1);
    checkOutput("ar_pre_data",  32'(out_data),  32'h1001);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_valid", 32'(out_valid), 32'd0);
    checkOutput("ar_data",  32'(out_data),  32'd0);
    checkOutput("ar_sel",   32'(out_sel),   32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muxn_stage.md
Name: muxn_stage

Overview:
- Parametrised N-way select mux for datapath forwarding and writeback selection, successor to the fixed six-input select mux.
- Selected word is captured in a pipeline register with valid/ready handshake, flush and sticky out-of-range-select flag.
- Sits between pipeline stages wherever a selected operand must be registered and back-pressure must propagate.

Parameters:
WIDTH, 16, data word width in bits (>=1)
NUM_IN, 6, number of selectable inputs (2..32)
SEL_W, $clog2(NUM_IN), select width (derived, not overridden)
DEFAULT_IDX, 0, input index used when sel >= NUM_IN

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous: drops held and incoming word
in_valid  input  1  upstream word valid
in_ready  output  1  stage can accept this cycle
sel  input  SEL_W  input index, sampled with in_valid
data_in  input  NUM_IN*WIDTH  packed inputs, input i at [i*WIDTH +: WIDTH]
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts
out_data  output  WIDTH  registered selected word
out_sel  output  SEL_W  effective index that produced out_data
sel_err  output  1  sticky: a sel >= NUM_IN was accepted
err_clr  input  1  clears sel_err

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_sel=0, sel_err=0; in_ready reflects the empty stage (=1) once rst deasserts.
- Combinational selection: idx = (sel < NUM_IN) ? sel : DEFAULT_IDX; word = data_in[idx*WIDTH +: WIDTH].
- Accept: fire_in = in_valid & in_ready. Emit: fire_out = out_valid & out_ready.
- Base mode (no skid): in_ready = !out_valid | out_ready (combinational path from out_ready).
- On fire_in: out_data<=word, out_sel<=idx, out_valid<=1 on the next edge; latency 1 cycle.
- fire_out without fire_in: out_valid<=0. Simultaneous fire_in and fire_out: new word replaces the old one, out_valid stays 1, full throughput.
- out_data and out_sel hold stable while out_valid=1 and out_ready=0, regardless of data_in or sel changes.
- flush=1: out_valid<=0 and no word is accepted that cycle, even if in_valid=1. in_ready is unaffected. out_data keeps its last value.
- sel_err: set on any fire_in with sel >= NUM_IN. err_clr=1 clears it. If set and clear occur in the same cycle, set wins. flush does not clear it.
- NUM_IN a power of two: sel_err is constant 0.
- rst asserted mid-transfer: the held word is lost; outputs return to reset values immediately.

Optional Feature:
- Macro MUXN_STAGE_SKID_EN.
- Defined:
  - Adds a one-entry skid register (skid_data, skid_sel, skid_valid) so in_ready is registered: in_ready = !skid_valid.
  - If a word is accepted while out_valid=1 and out_ready=0, it goes to the skid register.
  - On the next fire_out, the skid entry moves to the output and skid_valid<=0.
  - flush clears skid_valid and out_valid.
  - Reset: skid_valid=0.
  - Latency unchanged (1 cycle). Throughput 1/cycle. Capacity 2 words.
- Undefined: base mode above, with capacity 1 word and combinational in_ready.

Decomposition:
- Package muxn_pkg:
  - constants MUXN_MAX_IN=32, MUXN_DEF_WIDTH=16
  - function muxn_idx(sel, num_in, default_idx) returning the effective index
- Sub-module muxn_sel: purely combinational N-way word select (packed input, index in, word out), instantiated once.
- The handshake/register logic lives in muxn_stage.

Test Plan:
- Reset then single word: WIDTH=16, NUM_IN=6, input i=16'h1000+i, sel=3, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=16'h1003, out_sel=3, sel_err=0.
- Out-of-range select: sel=6 then sel=7 -> out_data=16'h1000, out_sel=0, sel_err=1 and sticky. err_clr=1 pulsed -> sel_err=0. err_clr and a bad sel in the same cycle -> sel_err stays 1.
- Back-pressure hold: accept sel=2, hold out_ready=0 for 4 cycles while changing data_in -> out_data stays 16'h1002. Base mode: in_ready=0. Skid mode: one more word (sel=4) accepted, then in_ready=0. Release -> 16'h1002 then 16'h1004, in order.
- Full throughput: in_valid=1, out_ready=1, sel cycling 0..5 for 12 cycles -> 12 outputs back-to-back with no bubbles, values 16'h1000..16'h1005 repeating.
- Flush: word held with out_ready=0, then flush=1 with in_valid=1 -> next cycle out_valid=0 (and skid empty in skid mode), the incoming word is not emitted, sel_err unchanged.
- Async reset mid-stream: assert rst between clock edges while out_valid=1 -> out_valid=0, out_data=0 immediately, before the next clk edge.
